instr_issue: RTL

//  Instruction fetch/issue unit: the producer side of the 8-bit instruction bus consumed by the Controller.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/instr_classify.sv | 19 +
 rtl/instr_issue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared SimpleCPU opcodes and instruction issue FSM encoding
package cpu_pkg;

   localparam logic [3:0] OP_SUM   = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0010;
   localparam logic [3:0] OP_LOAD  = 4'b0100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_ISSUE = 3'd3,
      S_HALT  = 3'd4
   } issue_state_e;

endpackage : cpu_pkg

// File: rtl/instr_classify.sv
// rtl/instr_classify.sv - combinational opcode check shared by issue and decode
module instr_classify
   import cpu_pkg::*;
(
   input  logic [7:0] instr,
   output logic       is_legal,
   output logic       is_halt
);

   logic [3:0] opcode;
   logic       unused_operand;

   assign opcode         = instr[7:4];
   assign unused_operand = ^instr[3:0];

   assign is_legal = (opcode == OP_SUM) || (opcode == OP_STORE) || (opcode == OP_LOAD);
   assign is_halt  = (opcode == OP_HALT);

endmodule : instr_classify

// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - fetches program words and issues legal instructions over valid/ready
module instr_issue
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              bad_op
);

   localparam logic [ADDR_W-1:0] PC_MAX = '1;

   issue_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              mem_rd_q, mem_rd_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;
   logic              bad_op_q, bad_op_d;
   logic              rdata_legal, rdata_halt;

   instr_classify u_classify (
      .instr    (mem_rdata),
      .is_legal (rdata_legal),
      .is_halt  (rdata_halt)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      bad_op_d = bad_op_q;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d  = S_FETCH;
               pc_d     = '0;
               bad_op_d = 1'b0;
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            instr_d = mem_rdata;
            if (rdata_halt) begin
               state_d = S_HALT;
            end else if (!rdata_legal) begin
               bad_op_d = 1'b1;
               if (pc_q == PC_MAX) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Last address retires into HALT so the pc never wraps to 0.
            if (instr_ready) begin
               if (pc_q == PC_MAX) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      mem_rd_d      = (state_d == S_FETCH);
      instr_valid_d = (state_d == S_ISSUE);
      busy_d        = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_ISSUE);
      halted_d      = (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         instr_q       <= 8'h00;
         instr_valid_q <= 1'b0;
         mem_rd_q      <= 1'b0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
         bad_op_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         mem_rd_q      <= mem_rd_d;
         busy_q        <= busy_d;
         halted_q      <= halted_d;
         bad_op_q      <= bad_op_d;
      end
   end

   assign mem_rd      = mem_rd_q;
   assign mem_addr    = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign bad_op      = bad_op_q;

endmodule : instr_issue
